// File: rtl/trap_pkg.sv
// Shared definitions for the illegal-instruction trap controller:
// FSM state encoding, cause sub-codes and architectural constants.
package trap_pkg;

    // Controller FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALT     = 2'd3
    } trap_state_e;

    // Cause sub-codes reported on err_code
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_OPC   = 2'd1;
    localparam logic [1:0] ERR_F3    = 2'd2;
    localparam logic [1:0] ERR_SHAMT = 2'd3;

    // Default fetch address on trap entry
    localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;

    // Architectural mcause value for an illegal instruction
    localparam logic [31:0] MCAUSE_ILLEGAL = 32'd2;

endpackage

// File: rtl/trap_cause_enc.sv
// Priority encoder for the decode error vector. Bad opcode outranks bad
// funct3, which outranks bad shift immediate; only the winner is reported.
module trap_cause_enc
    import trap_pkg::*;
(
    input  logic [2:0] dec_error,
    output logic [1:0] err_code,
    output logic       trap
);

    // Pick the highest-priority cause and flag any error at all
    always_comb begin
        err_code = ERR_NONE;
        if (dec_error[0]) begin
            err_code = ERR_OPC;
        end else if (dec_error[1]) begin
            err_code = ERR_F3;
        end else if (dec_error[2]) begin
            err_code = ERR_SHAMT;
        end
        trap = |dec_error;
    end

endmodule

// File: rtl/illegal_trap_ctrl.sv
// Illegal-instruction trap controller. Captures trap state for a faulting
// decode, flushes the front end, redirects fetch to the trap vector, handles
// mret back to the saved PC and halts on a fault taken inside the handler.
// Handshakes: decode transfers when dec_valid && dec_ready; fetch takes the
// redirect when redirect_valid && redirect_ready, and redirect_pc stays
// stable while redirect_valid is high and not yet accepted.
module illegal_trap_ctrl
    import trap_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [31:0]      dec_pc,
    input  logic [31:0]      dec_instr,
    input  logic [2:0]       dec_error,
    input  logic             mret_valid,
    output logic             flush,
    output logic             stall,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [31:0]      redirect_pc,
    output logic [31:0]      mepc,
    output logic [31:0]      mtval,
    output logic [1:0]       err_code,
    output logic             in_trap,
    output logic             fatal,
    output logic [CNT_W-1:0] trap_count
);

    trap_state_e      state_q, state_d;
    logic             flush_q, flush_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [31:0]      mepc_q, mepc_d;
    logic [31:0]      mtval_q, mtval_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             in_trap_q, in_trap_d;
    logic             fatal_q, fatal_d;
    logic [CNT_W-1:0] trap_count_q, trap_count_d;

    logic [1:0]       enc_code;
    logic             enc_trap;
    logic             handshake;

    trap_cause_enc u_cause_enc (
        .dec_error (dec_error),
        .err_code  (enc_code),
        .trap      (enc_trap)
    );

    assign handshake = dec_valid && (state_q == ST_IDLE);

    // Next-state and next-output computation for the trap FSM
    always_comb begin
        state_d          = state_q;
        flush_d          = 1'b0;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        mepc_d           = mepc_q;
        mtval_d          = mtval_q;
        err_code_d       = err_code_q;
        in_trap_d        = in_trap_q;
        fatal_d          = fatal_q;
        trap_count_d     = trap_count_q;

        case (state_q)
            ST_IDLE: begin
                redirect_valid_d = 1'b0;
                if (handshake && enc_trap) begin
                    // An error always wins over a simultaneous mret
                    if (!in_trap_q) begin
                        mepc_d     = dec_pc;
                        mtval_d    = dec_instr;
                        err_code_d = enc_code;
                        in_trap_d  = 1'b1;
                        if (trap_count_q != {CNT_W{1'b1}}) begin
                            trap_count_d = trap_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                        flush_d = 1'b1;
                        state_d = ST_FLUSH;
                    end else begin
                        // Fault inside the handler: keep the first fault's state
                        fatal_d = 1'b1;
                        state_d = ST_HALT;
                    end
                end else if (handshake && mret_valid && in_trap_q) begin
                    redirect_pc_d = mepc_q;
                    in_trap_d     = 1'b0;
                    err_code_d    = ERR_NONE;
                    flush_d       = 1'b1;
                    state_d       = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // in_trap still set here means this flush came from trap entry
                if (in_trap_q) begin
                    redirect_pc_d = TRAP_VECTOR;
                end
                redirect_valid_d = 1'b1;
                state_d          = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    redirect_valid_d = 1'b0;
                    state_d          = ST_IDLE;
                end
            end
            default: begin
                redirect_valid_d = 1'b0;
                fatal_d          = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset overrides any in-flight state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0;
            mepc_q           <= 32'h0;
            mtval_q          <= 32'h0;
            err_code_q       <= ERR_NONE;
            in_trap_q        <= 1'b0;
            fatal_q          <= 1'b0;
            trap_count_q     <= '0;
        end else begin
            state_q          <= state_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            mepc_q           <= mepc_d;
            mtval_q          <= mtval_d;
            err_code_q       <= err_code_d;
            in_trap_q        <= in_trap_d;
            fatal_q          <= fatal_d;
            trap_count_q     <= trap_count_d;
        end
    end

    assign dec_ready      = (state_q == ST_IDLE);
    assign stall          = (state_q != ST_IDLE);
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign mepc           = mepc_q;
    assign mtval          = mtval_q;
    assign err_code       = err_code_q;
    assign in_trap        = in_trap_q;
    assign fatal          = fatal_q;
    assign trap_count     = trap_count_q;

endmodule

// File: tb/tb_illegal_trap_ctrl.sv
// Testbench for illegal_trap_ctrl: directed scenarios plus randomized
// decode traffic against a behavioural model; redirect payloads are queued
// at issue time and checked by an independent monitor.
module tb_illegal_trap_ctrl;

  localparam logic [31:0] TV = 32'h0000_0100;
  localparam int W = 32 + 32 + 32 + 2 + 1 + 8;

  logic        clk;
  logic        rst_n;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic [2:0]  dec_error;
  logic        mret_valid;
  logic        flush;
  logic        stall;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic [31:0] mepc;
  logic [31:0] mtval;
  logic [1:0]  err_code;
  logic        in_trap;
  logic        fatal;
  logic [7:0]  trap_count;

  illegal_trap_ctrl #(.TRAP_VECTOR(TV), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_instr(dec_instr), .dec_error(dec_error),
    .mret_valid(mret_valid),
    .flush(flush), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc),
    .mepc(mepc), .mtval(mtval), .err_code(err_code),
    .in_trap(in_trap), .fatal(fatal), .trap_count(trap_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];

  // behavioural model of architectural trap state
  logic        m_in_trap;
  logic [31:0] m_mepc;
  logic [31:0] m_mtval;
  logic [1:0]  m_code;
  int          m_count;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_cause(input logic [2:0] e);
    if (e[0]) return 2'd1;
    if (e[1]) return 2'd2;
    if (e[2]) return 2'd3;
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_in_trap = 1'b0;
    m_mepc    = '0;
    m_mtval   = '0;
    m_code    = '0;
    m_count   = 0;
    exp_q.delete();
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check({tag, "_rst_flush"}, flush, 0);
    check({tag, "_rst_rv"}, redirect_valid, 0);
    check({tag, "_rst_rpc"}, redirect_pc, 0);
    check({tag, "_rst_regs"}, {mepc, mtval, err_code, in_trap, fatal, trap_count}, 0);
    check({tag, "_rst_stall"}, stall, 0);
    check({tag, "_rst_ready"}, dec_ready, 1);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check({tag, "_post_ready"}, dec_ready, 1);
  endtask

  // ---------------- driver tasks ----------------
  // kind: 0 nothing accepted/ignored, 1 trap entry, 2 mret, 3 double fault
  task automatic issue(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [2:0] err, input logic mret, output int kind);
    logic [31:0] exp_rpc;
    logic [31:0] prev_mepc;
    dec_valid  = v;
    dec_pc     = pc;
    dec_instr  = instr;
    dec_error  = err;
    mret_valid = mret;
    kind       = 0;
    prev_mepc  = m_mepc;
    if (v && dec_ready) begin
      if (err != 3'b000) begin
        if (!m_in_trap) begin
          m_in_trap = 1'b1;
          m_mepc    = pc;
          m_mtval   = instr;
          m_code    = model_cause(err);
          if (m_count < 255) m_count++;
          exp_q.push_back({TV, m_mepc, m_mtval, m_code, 1'b1, 8'(m_count)});
          kind = 1;
        end else begin
          kind = 3;
        end
      end else if (mret && m_in_trap) begin
        m_in_trap = 1'b0;
        m_code    = 2'd0;
        exp_q.push_back({m_mepc, m_mepc, m_mtval, 2'd0, 1'b0, 8'(m_count)});
        kind = 2;
      end
    end
    @(posedge clk); #1;
    dec_valid  = 1'b0;
    dec_error  = 3'b000;
    mret_valid = 1'b0;
    check("state_regs", {mepc, mtval, err_code, in_trap, trap_count},
          {m_mepc, m_mtval, m_code, m_in_trap, 8'(m_count)});
    if (kind == 1 || kind == 2) begin
      check("flush_on", flush, 1);
      check("stall_flush", stall, 1);
      check("rv_flush", redirect_valid, 0);
      exp_rpc = (kind == 1) ? TV : prev_mepc;
      @(posedge clk); #1;
      check("flush_off", flush, 0);
      check("rv_on", redirect_valid, 1);
      check("rpc", redirect_pc, exp_rpc);
    end else if (kind == 3) begin
      check("fatal_on", fatal, 1);
      check("halt_ready", dec_ready, 0);
      check("halt_flush", flush, 0);
    end else begin
      check("idle_flush", flush, 0);
      check("idle_rv", redirect_valid, 0);
      check("idle_ready", dec_ready, 1);
    end
  endtask

  // hold redirect_ready low for 'hold' cycles, then accept
  task automatic complete_redirect(input int hold);
    logic [31:0] rpc;
    rpc = redirect_pc;
    for (int i = 0; i < hold; i++) begin
      check("rv_held", redirect_valid, 1);
      check("rpc_stable", redirect_pc, rpc);
      @(posedge clk); #1;
    end
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    check("back_idle", dec_ready, 1);
    check("rv_off", redirect_valid, 0);
    check("stall_off", stall, 0);
  endtask

  task automatic op(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                    input logic [2:0] err, input logic mret, input int hold);
    int k;
    issue(v, pc, instr, err, mret, k);
    if (k == 1 || k == 2) complete_redirect(hold);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && redirect_valid && redirect_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL redirect_unexpected: got pc %0h expected none", redirect_pc);
      end else begin
        check("redirect_payload",
              {redirect_pc, mepc, mtval, err_code, in_trap, trap_count},
              exp_q.pop_front());
      end
    end
  end

  // watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] pc, saved;
    logic [2:0]  e;
    int          k;
    rst_n = 1'b0; dec_valid = 1'b0; dec_pc = '0; dec_instr = '0;
    dec_error = '0; mret_valid = 1'b0; redirect_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_reset("init");

    // trap entry with fetch back-pressure, then mret
    op(1'b1, 32'h40, 32'h0, 3'b001, 1'b0, 3);
    check("t2_mepc", mepc, 32'h40);
    check("t2_code", err_code, 1);
    op(1'b1, 32'h44, 32'h0, 3'b000, 1'b1, 0);
    check("t4_intrap", in_trap, 0);

    // cause priority, mret flagged alongside an error is a trap
    op(1'b1, 32'h80, 32'h1234_5678, 3'b110, 1'b1, 1);
    check("t3_code", err_code, 2);
    check("t3_mepc", mepc, 32'h80);
    op(1'b1, 32'h84, 32'h0, 3'b000, 1'b1, 2);

    // randomized traffic (no double faults here)
    for (int i = 0; i < 200; i++) begin
      pc = $urandom & 32'hFFFF_FFFC;
      e  = 3'($urandom_range(1, 7));
      if (m_in_trap || $urandom_range(0, 2) == 0) e = 3'b000;
      op(($urandom_range(0, 4) != 0), pc, $urandom, e, 1'($urandom_range(0, 1)),
         $urandom_range(0, 3));
    end

    // reset in the middle of a redirect
    do_reset("pre_t1");
    issue(1'b1, 32'h200, 32'hDEAD_BEEF, 3'b100, 1'b0, k);
    check("t1_in_redirect", redirect_valid, 1);
    do_reset("t1");

    // counter saturation
    for (int i = 0; i < 260; i++) begin
      op(1'b1, 32'h300, 32'h0, 3'b001, 1'b0, 0);
      op(1'b1, 32'h304, 32'h0, 3'b000, 1'b1, 0);
    end
    check("sat_count", trap_count, 8'hFF);

    // gating: mret outside handler, error without valid
    op(1'b1, 32'h500, 32'h0, 3'b000, 1'b1, 0);
    op(1'b0, 32'h504, 32'h0, 3'b111, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("gate_rv", redirect_valid, 0);
      check("gate_ready", dec_ready, 1);
      check("gate_intrap", in_trap, 0);
    end

    // double fault
    op(1'b1, 32'h600, 32'h0BAD_0000, 3'b010, 1'b0, 0);
    saved = mepc;
    issue(1'b1, 32'h700, 32'h0, 3'b100, 1'b0, k);
    check("df_kind", k, 3);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("df_ready", dec_ready, 0);
      check("df_fatal", fatal, 1);
      check("df_stall", stall, 1);
      check("df_rv", redirect_valid, 0);
      check("df_mepc", mepc, saved);
      check("df_code", err_code, 2);
    end
    do_reset("df");

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
